// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Bundles the command, ROM-wrapper and stream signals of rom_stream_reader.
//   master : sequencer view (drives busy/done/rom_cs/rom_addr/out_*/checksum/xor_sig)
//   slave  : environment view (drives start/base_addr/length/rom_dout/out_ready)
//   Signals:
//     start, base_addr, length     command inputs to the sequencer
//     busy, done                   status outputs
//     rom_cs, rom_addr, rom_dout   single-byte read port of the ROM wrapper
//     out_data, out_valid, out_ready  byte stream with valid/ready handshake
//     checksum, xor_sig            running content signatures
interface rom_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic                  rom_cs;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           checksum;
    logic [DATA_WIDTH-1:0] xor_sig;

    modport master (
        input  start, base_addr, length, rom_dout, out_ready,
        output busy, done, rom_cs, rom_addr, out_data, out_valid, checksum, xor_sig
    );

    modport slave (
        output start, base_addr, length, rom_dout, out_ready,
        input  busy, done, rom_cs, rom_addr, out_data, out_valid, checksum, xor_sig
    );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Reads a run of bytes from the 8x1024 ROM wrapper, one read outstanding at a
//   time, and streams each byte out on a valid/ready interface while keeping a
//   16-bit additive checksum and an XOR signature of the accepted bytes.
//   Ports:
//     clk    single clock, shared with the ROM wrapper
//     reset  synchronous, active-high
//     bus    rom_stream_reader_if.master (command, ROM port, stream, signatures)
//   Every output is a register. A read is: ISSUE (rom_cs high for one cycle),
//   WAIT (READ_LATENCY edges until rom_dout is sampled), HOLD (until accepted).
module rom_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    rom_stream_reader_if.master bus
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
        $error("rom_stream_reader: READ_LATENCY must be in 1..7");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = '0;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = 1;
    localparam logic [2:0]            LAT_LOAD  = 3'(READ_LATENCY);
    localparam logic [2:0]            LAT_ONE   = 3'd1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [2:0]            lat_cnt;
    logic                  handshake;

    assign handshake = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            lat_cnt       <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.rom_cs    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.checksum  <= '0;
            bus.xor_sig   <= '0;
        end else begin
            // NOTE: single-cycle pulses default low here; the case below only
            // raises them, so each pulse lasts exactly one cycle.
            bus.done   <= 1'b0;
            bus.rom_cs <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.checksum <= '0;
                        bus.xor_sig  <= '0;
                        if (bus.length != LEN_ZERO) begin
                            cur_addr     <= bus.base_addr;
                            remaining    <= bus.length;
                            // rom_cs/rom_addr are set one edge early so they
                            // are visible throughout the ISSUE cycle.
                            bus.rom_cs   <= 1'b1;
                            bus.rom_addr <= bus.base_addr;
                            bus.busy     <= 1'b1;
                            state        <= ISSUE;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end

                WAIT: begin
                    // The edge that takes lat_cnt from 1 to 0 is the
                    // READ_LATENCY-th edge after the ISSUE edge.
                    if (lat_cnt == LAT_ONE) begin
                        bus.out_data  <= bus.rom_dout;
                        bus.out_valid <= 1'b1;
                        lat_cnt       <= '0;
                        state         <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                    end
                end

                HOLD: begin
                    if (handshake) begin
                        bus.checksum  <= bus.checksum + 16'(bus.out_data);
                        bus.xor_sig   <= bus.xor_sig ^ bus.out_data;
                        bus.out_valid <= 1'b0;
                        remaining     <= remaining - LEN_ONE;
                        cur_addr      <= cur_addr + ADDR_STEP;
                        if (remaining == LEN_ONE) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Address wraps naturally at 2^ADDR_WIDTH.
                            bus.rom_cs   <= 1'b1;
                            bus.rom_addr <= cur_addr + ADDR_STEP;
                            state        <= ISSUE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Directed bench for rom_stream_reader with a latency-accurate ROM model.
module tb_rom_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rom_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rom_stream_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ROM image and wrapper model: address captured on the edge that ends the
    // rom_cs cycle, data valid for sampling RL edges after it, junk otherwise.
    function automatic logic [7:0] rom_byte(input int i);
        int v;
        v = (i * 7) ^ (i >> 2) ^ 32'hA5;
        return v[7:0];
    endfunction

    logic [7:0] rom_img [1024];
    logic [7:0] pipe [RL];

    initial begin
        for (int i = 0; i < 1024; i++) rom_img[i] = rom_byte(i);
    end

    always @(posedge clk) begin
        pipe[0] <= bus.rom_cs ? rom_img[bus.rom_addr] : 8'hEE;
        for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end

    assign bus.rom_dout = pipe[RL-1];

    // Monitor: everything sampled on the falling edge.
    int cycle = 0;
    int cs_count = 0;
    int hs_count = 0;
    int done_count = 0;
    int busy_cycles = 0;
    int done_cycle = 0;
    logic busy_at_done = 1'b0;
    logic [9:0] addr_q[$];
    logic [7:0] data_q[$];
    int hs_cyc_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rom_cs) begin
                cs_count++;
                addr_q.push_back(bus.rom_addr);
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_count++;
                data_q.push_back(bus.out_data);
                hs_cyc_q.push_back(cycle);
            end
            if (bus.done) begin
                done_count++;
                done_cycle   = cycle;
                busy_at_done = bus.busy;
            end
            if (bus.busy) busy_cycles++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] l);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.length    = l;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n;
        int d0;
        n  = 0;
        d0 = done_count;
        while (done_count == d0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        check(tag, 32'(done_count != d0), 32'd1);
    endtask

    // Snapshot indices so each test reads only its own monitor records.
    int cs0, hs0, done0, busy0, aq0, dq0, hq0;
    task automatic snap();
        cs0   = cs_count;
        hs0   = hs_count;
        done0 = done_count;
        busy0 = busy_cycles;
        aq0   = addr_q.size();
        dq0   = data_q.size();
        hq0   = hs_cyc_q.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_basic [4];
        logic [7:0]  exp_bp [3];
        logic [9:0]  wrap_addr [4];
        logic [15:0] sum_m;
        logic [7:0]  xor_m;
        logic [7:0]  d;
        int          n;
        int          errs;
        int          cs_before;

        exp_basic = '{8'hD1, 8'hD6, 8'hDF, 8'h24};
        exp_bp    = '{8'h75, 8'h72, 8'h7B};
        wrap_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cs", 32'(bus.rom_cs), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_sum", 32'(bus.checksum), 32'd0);
        check("rst_xor", 32'(bus.xor_sig), 32'd0);

        // Basic stream: 0x010, 4 bytes, consumer always ready
        snap();
        bus.out_ready = 1'b1;
        do_start(10'h010, 11'd4);
        wait_done("basic_done", 100);
        check("basic_cs_cnt", 32'(cs_count - cs0), 32'd4);
        check("basic_hs_cnt", 32'(hs_count - hs0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("basic_addr%0d", k), 32'(addr_q[aq0+k]), 32'(10'h010 + k));
            check($sformatf("basic_data%0d", k), 32'(data_q[dq0+k]), 32'(exp_basic[k]));
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("basic_gap%0d", k), 32'(hs_cyc_q[hq0+k+1] - hs_cyc_q[hq0+k]), 32'd4);
        check("basic_done_lat", 32'(done_cycle - hs_cyc_q[hq0+3]), 32'd1);
        check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
        check("basic_done_cnt", 32'(done_count - done0), 32'd1);
        check("basic_sum", 32'(bus.checksum), 32'h02AA);
        check("basic_xor", 32'(bus.xor_sig), 32'hFC);

        // Backpressure: 3 bytes from 0x040, byte 2 stalled for 5 cycles
        snap();
        bus.out_ready = 1'b0;
        do_start(10'h040, 11'd3);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'd1);
            d = bus.out_data;
            check($sformatf("bp_data%0d", k), 32'(d), 32'(exp_bp[k]));
            if (k == 1) begin
                errs      = 0;
                cs_before = cs_count;
                repeat (5) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.out_data !== d) errs++;
                end
                check("bp_stable", 32'(errs), 32'd0);
                check("bp_no_cs", 32'(cs_count - cs_before), 32'd0);
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
            @(posedge clk); #1 bus.out_ready = 1'b0;
        end
        wait_done("bp_done", 50);
        check("bp_hs_cnt", 32'(hs_count - hs0), 32'd3);
        check("bp_addr2", 32'(addr_q[aq0+2]), 32'h042);
        check("bp_sum", 32'(bus.checksum), 32'h0162);
        check("bp_xor", 32'(bus.xor_sig), 32'h7C);

        // Wrap-around: 0x3FE, 4 bytes
        snap();
        bus.out_ready = 1'b1;
        do_start(10'h3FE, 11'd4);
        wait_done("wrap_done", 100);
        check("wrap_cs_cnt", 32'(cs_count - cs0), 32'd4);
        sum_m = '0;
        xor_m = '0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wrap_addr%0d", k), 32'(addr_q[aq0+k]), 32'(wrap_addr[k]));
            check($sformatf("wrap_data%0d", k), 32'(data_q[dq0+k]), 32'(rom_byte(int'(wrap_addr[k]))));
            sum_m += 16'(rom_byte(int'(wrap_addr[k])));
            xor_m ^= rom_byte(int'(wrap_addr[k]));
        end
        check("wrap_sum", 32'(bus.checksum), 32'(sum_m));
        check("wrap_xor", 32'(bus.xor_sig), 32'(xor_m));

        // Zero length
        snap();
        do_start(10'h100, 11'd0);
        wait_done("zero_done", 5);
        repeat (5) @(negedge clk);
        check("zero_cs", 32'(cs_count - cs0), 32'd0);
        check("zero_busy", 32'(busy_cycles - busy0), 32'd0);
        check("zero_done_cnt", 32'(done_count - done0), 32'd1);
        check("zero_sum", 32'(bus.checksum), 32'd0);
        check("zero_xor", 32'(bus.xor_sig), 32'd0);

        // Full ROM with a start injected mid-run
        snap();
        do_start(10'h000, 11'd1024);
        repeat (500) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 10'h123;
        bus.length    = 11'd5;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done("full_done", 5000);
        check("full_hs_cnt", 32'(hs_count - hs0), 32'd1024);
        check("full_cs_cnt", 32'(cs_count - cs0), 32'd1024);
        check("full_done_cnt", 32'(done_count - done0), 32'd1);
        sum_m = '0;
        xor_m = '0;
        errs  = 0;
        for (int i = 0; i < 1024; i++) begin
            sum_m += 16'(rom_img[i]);
            xor_m ^= rom_img[i];
            if (addr_q[aq0+i] !== 10'(i)) errs++;
            if (data_q[dq0+i] !== rom_img[i]) errs++;
        end
        check("full_seq_errs", 32'(errs), 32'd0);
        check("full_sum", 32'(bus.checksum), 32'(sum_m));
        check("full_xor", 32'(bus.xor_sig), 32'(xor_m));
        repeat (6) @(negedge clk);
        check("full_sum_stable", 32'(bus.checksum), 32'(sum_m));
        check("full_busy_idle", 32'(bus.busy), 32'd0);

        // Reset during WAIT of byte 3, then a clean restart
        snap();
        do_start(10'h080, 11'd5);
        n = 0;
        while ((cs_count - cs0) < 3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("rstop_reach_b3", 32'(cs_count - cs0), 32'd3);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rstop_cs", 32'(bus.rom_cs), 32'd0);
        check("rstop_valid", 32'(bus.out_valid), 32'd0);
        check("rstop_busy", 32'(bus.busy), 32'd0);
        check("rstop_done", 32'(bus.done), 32'd0);
        repeat (10) @(negedge clk);
        check("rstop_no_done", 32'(done_count - done0), 32'd0);
        check("rstop_no_cs", 32'(cs_count - cs0), 32'd3);
        snap();
        do_start(10'h020, 11'd2);
        wait_done("restart_done", 50);
        check("restart_addr0", 32'(addr_q[aq0]), 32'h020);
        check("restart_addr1", 32'(addr_q[aq0+1]), 32'h021);
        check("restart_sum", 32'(bus.checksum), 32'h0097);
        check("restart_xor", 32'(bus.xor_sig), 32'h07);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Sequencer directly upstream of the 8x1024 ROM wrapper.
- Accepts a start command with base address and length, and issues single-byte reads by driving the wrapper's cs/addr.
- Captures each dout byte and streams it out on a valid/ready interface.
- Accumulates a 16-bit additive checksum and an 8-bit XOR signature for built-in ROM content checking on the testchip.

Parameters:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 10, ROM address width.
- READ_LATENCY, 2, cycles from the cycle rom_cs is high to the rising edge at which rom_dout is sampled (min 1, max 7).

Ports:
- clk  input  1  single clock, shared with the ROM wrapper.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first ROM address, latched on start.
- length  input  ADDR_WIDTH+1  number of bytes to read (0..1024), latched on start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the transfer completes.
- rom_cs  output  1  to wrapper cs; active high, one cycle per read.
- rom_addr  output  ADDR_WIDTH  to wrapper addr.
- rom_dout  input  DATA_WIDTH  from wrapper dout.
- out_data  output  DATA_WIDTH  streamed byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte.
- checksum  output  16  running sum of accepted bytes, modulo 2^16.
- xor_sig  output  DATA_WIDTH  running XOR of accepted bytes.

Behaviour:
- Reset values: all outputs 0, state IDLE, latency counter 0. Checksum and xor_sig are cleared only by reset or by an accepted start.
- All outputs are registered. rom_cs is high for exactly one cycle per read. rom_addr holds its value between reads.
- IDLE:
  - On start with length != 0: latch base_addr into cur_addr and length into remaining; clear checksum and xor_sig; go to ISSUE.
  - On start with length == 0: clear checksum and xor_sig; pulse done on the next cycle; stay in IDLE (busy never rises).
- ISSUE (1 cycle): rom_cs=1, rom_addr=cur_addr; load lat_cnt=READ_LATENCY; go to WAIT.
- WAIT:
  - rom_cs=0; decrement lat_cnt each cycle.
  - At the edge where lat_cnt reaches 0: capture rom_dout into out_data, set out_valid=1, go to HOLD.
  - Net effect: dout is sampled READ_LATENCY edges after the ISSUE edge.
- HOLD:
  - out_data and out_valid stay stable until out_ready is high (no data change while valid and not ready).
  - On handshake (out_valid && out_ready): checksum += out_data; xor_sig ^= out_data; remaining -= 1; cur_addr += 1 (wraps modulo 2^ADDR_WIDTH, so 1023 -> 0); out_valid=0 next cycle.
  - If remaining was 1: go to IDLE and pulse done in the same cycle busy falls. Otherwise go to ISSUE.
- Reads are strictly serialised, with one read outstanding at most.
- Throughput with out_ready held high: one byte per READ_LATENCY+2 cycles.
- start while busy is ignored; latched parameters are unchanged.
- Reset mid-transfer: the next cycle shows rom_cs=0, out_valid=0, busy=0, done=0. No done pulse is produced for the aborted transfer.
- out_ready while out_valid is low has no effect.
- The checksum and xor_sig values are final and stable from the done pulse until the next accepted start.

Test Plan:
- Basic stream: base_addr=0x010, length=4, out_ready=1 -> rom_cs pulses with addr 0x010..0x013; out_data equals ROM[0x010..0x013] in order; done one cycle after the 4th handshake; checksum equals the sum of those 4 bytes; each byte spaced 4 cycles apart (READ_LATENCY=2).
- Backpressure: length=3, out_ready low for 5 cycles on byte 2 -> out_data and out_valid are held stable; no rom_cs asserts during the stall; totals are unaffected.
- Wrap-around: base_addr=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; done after 4 bytes.
- Zero length: start with length=0 -> no rom_cs; busy stays 0; done pulses once; checksum=0, xor_sig=0.
- Full ROM: base_addr=0, length=1024 -> exactly 1024 handshakes; checksum and xor_sig match the golden ROM image; a start pulse injected mid-run is ignored.
- Reset mid-op: reset asserted during WAIT of byte 3 -> next cycle rom_cs=0, out_valid=0, busy=0; no done pulse; a subsequent start with base_addr=0x020, length=2 runs normally with cleared checksum.
